// File: rtl/fa_pkg.sv
// ---------------------------------------------------------------------------
// fa_pkg
// Shared definitions for the convolution/pooling engine, the writeback
// serializer and the DMA write path: burst geometry, word/address widths
// and the serializer state encoding.
// ---------------------------------------------------------------------------
package fa_pkg;

    localparam int BURST_LEN = 16;  // lanes per result burst
    localparam int DATA_W    = 16;  // bits per result word
    localparam int ADDR_W    = 30;  // DMA word-address width
    localparam int LANES_W   = 5;   // width of a lane count (0..31)
    localparam int TOTAL_W   = 24;  // width of per-layer word counters

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/burst_fifo2.sv
// ---------------------------------------------------------------------------
// burst_fifo2
// Two-entry ping-pong buffer for result bursts. Each entry holds one burst
// of data plus its (already clamped) lane count.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush_i        drop all entries (same effect as reset on the pointers)
//   push_i         write push_data_i/push_lanes_i into the tail entry
//   push_data_i    burst data
//   push_lanes_i   burst lane count
//   pop_i          retire the head entry
//   head_data_o    data of the head entry
//   head_lanes_o   lane count of the head entry
//   full_o         both entries occupied
//   empty_o        no entry occupied
// ---------------------------------------------------------------------------
module burst_fifo2
    import fa_pkg::*;
#(
    parameter int DATA_BITS = BURST_LEN * DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] push_data_i,
    input  logic [LANES_W-1:0]   push_lanes_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] head_data_o,
    output logic [LANES_W-1:0]   head_lanes_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [DATA_BITS-1:0] data_q  [2];
    logic [LANES_W-1:0]   lanes_q [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 do_push, do_pop;

    // A push into a full buffer is allowed only when the head leaves in the
    // same cycle; occupancy then stays at two.
    assign do_push = push_i && ((count_q != 2'd2) || pop_i);
    assign do_pop  = pop_i && (count_q != 2'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[wr_ptr_q]  <= push_data_i;
            lanes_q[wr_ptr_q] <= push_lanes_i;
        end
    end

    assign head_data_o  = data_q[rd_ptr_q];
    assign head_lanes_o = lanes_q[rd_ptr_q];
    assign full_o       = (count_q == 2'd2);
    assign empty_o      = (count_q == 2'd0);

endmodule

// File: rtl/wb_serializer.sv
// ---------------------------------------------------------------------------
// wb_serializer
// Writeback serializer between the convolution/pooling engine and DMA write
// port p0. Parallel result bursts are buffered two deep and streamed one
// word per DMA read strobe. Burst start addresses advance from the layer
// base address by the lane count of each burst. A one-cycle done pulse is
// raised when the programmed number of words has been handed over.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              arm a layer (only honoured in IDLE)
//   result_start_addr  layer base word address, sampled on start
//   total_words        words to write this layer, sampled on start
//   res_data           burst data, lane i at [16i+15:16i]
//   res_lanes          valid lanes from lane 0 (0 or >BURST_LEN = BURST_LEN)
//   res_valid/ready    burst handshake
//   dma_p0_writes_en   write command enable, held for the whole layer
//   p0_addr            start address of the burst being sent
//   dma_p0_ib_re       DMA strobe requesting the next word
//   dma_p0_ib_data     word to DMA, registered one edge after the strobe
//   dma_p0_ib_valid    dma_p0_ib_data valid (one cycle per strobe)
//   wb_busy            layer in progress
//   wb_done            one-cycle completion pulse
// ---------------------------------------------------------------------------
module wb_serializer #(
    parameter int BURST_LEN = fa_pkg::BURST_LEN,
    parameter int ADDR_W    = fa_pkg::ADDR_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [ADDR_W-1:0]                    result_start_addr,
    input  logic [fa_pkg::TOTAL_W-1:0]           total_words,
    input  logic [BURST_LEN*fa_pkg::DATA_W-1:0]  res_data,
    input  logic [fa_pkg::LANES_W-1:0]           res_lanes,
    input  logic                                 res_valid,
    output logic                                 res_ready,
    output logic                                 dma_p0_writes_en,
    output logic [ADDR_W-1:0]                    p0_addr,
    input  logic                                 dma_p0_ib_re,
    output logic [fa_pkg::DATA_W-1:0]            dma_p0_ib_data,
    output logic                                 dma_p0_ib_valid,
    output logic                                 wb_busy,
    output logic                                 wb_done
);

    import fa_pkg::*;

    localparam int DW = DATA_W;
    localparam int LW = LANES_W;
    localparam int TW = TOTAL_W;
    localparam int BW = BURST_LEN * DW;

    wb_state_e         state_q, state_d;
    logic [TW-1:0]     total_q, total_d;
    logic [TW-1:0]     words_sent_q, words_sent_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] p0_addr_q, p0_addr_d;
    logic [LW-1:0]     lane_idx_q, lane_idx_d;
    logic [LW-1:0]     cur_lanes_q, cur_lanes_d;
    logic [BW-1:0]     cur_data_q, cur_data_d;
    logic              wen_q, wen_d;
    logic              ovld_q, ovld_d;
    logic [DW-1:0]     odata_q, odata_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;
    logic [BW-1:0]     head_data;
    logic [LW-1:0]     head_lanes;

    // Lane counts are normalised once, on entry to the buffer.
    function automatic logic [LW-1:0] clamp_lanes(input logic [LW-1:0] lanes);
        if ((lanes == '0) || (lanes > LW'(BURST_LEN))) begin
            return LW'(BURST_LEN);
        end
        return lanes;
    endfunction

    assign res_ready = !fifo_full && ((state_q == ARMED) || (state_q == SEND));
    assign fifo_push = res_valid && res_ready;

    burst_fifo2 #(
        .DATA_BITS (BW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (fifo_flush),
        .push_i       (fifo_push),
        .push_data_i  (res_data),
        .push_lanes_i (clamp_lanes(res_lanes)),
        .pop_i        (fifo_pop),
        .head_data_o  (head_data),
        .head_lanes_o (head_lanes),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        words_sent_d = words_sent_q;
        next_addr_d  = next_addr_q;
        p0_addr_d    = p0_addr_q;
        lane_idx_d   = lane_idx_q;
        cur_lanes_d  = cur_lanes_q;
        cur_data_d   = cur_data_q;
        wen_d        = wen_q;
        ovld_d       = 1'b0;
        odata_d      = odata_q;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    total_d      = total_words;
                    words_sent_d = '0;
                    next_addr_d  = result_start_addr;
                    state_d      = (total_words == '0) ? DONE : ARMED;
                end
            end

            ARMED: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cur_data_d  = head_data;
                    cur_lanes_d = head_lanes;
                    p0_addr_d   = next_addr_q;
                    lane_idx_d  = '0;
                    wen_d       = 1'b1;
                    state_d     = SEND;
                end
            end

            SEND: begin
                if (dma_p0_ib_re) begin
                    ovld_d       = 1'b1;
                    odata_d      = cur_data_q[DW*lane_idx_q +: DW];
                    words_sent_d = words_sent_q + TW'(1);
                    lane_idx_d   = lane_idx_q + LW'(1);
                    // Reaching the layer total wins over a burst boundary;
                    // whatever is left of the burst is dropped.
                    if ((words_sent_q + TW'(1)) == total_q) begin
                        state_d = DONE;
                    end else if ((lane_idx_q + LW'(1)) == cur_lanes_q) begin
                        next_addr_d = next_addr_q + ADDR_W'(cur_lanes_q);
                        if (!fifo_empty) begin
                            // Chain straight into the next burst so the
                            // word stream has no bubble.
                            fifo_pop    = 1'b1;
                            cur_data_d  = head_data;
                            cur_lanes_d = head_lanes;
                            p0_addr_d   = next_addr_d;
                            lane_idx_d  = '0;
                        end else begin
                            state_d = ARMED;
                        end
                    end
                end
            end

            DONE: begin
                fifo_flush = 1'b1;
                wen_d      = 1'b0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            total_q      <= '0;
            words_sent_q <= '0;
            next_addr_q  <= '0;
            p0_addr_q    <= '0;
            lane_idx_q   <= '0;
            cur_lanes_q  <= '0;
            wen_q        <= 1'b0;
            ovld_q       <= 1'b0;
            odata_q      <= '0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            words_sent_q <= words_sent_d;
            next_addr_q  <= next_addr_d;
            p0_addr_q    <= p0_addr_d;
            lane_idx_q   <= lane_idx_d;
            cur_lanes_q  <= cur_lanes_d;
            wen_q        <= wen_d;
            ovld_q       <= ovld_d;
            odata_q      <= odata_d;
        end
    end

    // Burst payload being sent; qualified by state, so no reset needed.
    always_ff @(posedge clk) begin
        cur_data_q <= cur_data_d;
    end

    assign dma_p0_writes_en = wen_q;
    assign p0_addr          = p0_addr_q;
    assign dma_p0_ib_data   = odata_q;
    assign dma_p0_ib_valid  = ovld_q;
    assign wb_busy          = (state_q == ARMED) || (state_q == SEND);
    assign wb_done          = (state_q == DONE);

endmodule

// File: tb/tb_wb_serializer.sv
module tb_wb_serializer;

    localparam int BL = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [29:0]  result_start_addr;
    logic [23:0]  total_words;
    logic [BL*16-1:0] res_data;
    logic [4:0]   res_lanes;
    logic         res_valid;
    logic         res_ready;
    logic         dma_p0_writes_en;
    logic [29:0]  p0_addr;
    logic         dma_p0_ib_re;
    logic [15:0]  dma_p0_ib_data;
    logic         dma_p0_ib_valid;
    logic         wb_busy;
    logic         wb_done;

    wb_serializer #(.BURST_LEN(BL), .ADDR_W(30)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .result_start_addr (result_start_addr),
        .total_words       (total_words),
        .res_data          (res_data),
        .res_lanes         (res_lanes),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .dma_p0_writes_en  (dma_p0_writes_en),
        .p0_addr           (p0_addr),
        .dma_p0_ib_re      (dma_p0_ib_re),
        .dma_p0_ib_data    (dma_p0_ib_data),
        .dma_p0_ib_valid   (dma_p0_ib_valid),
        .wb_busy           (wb_busy),
        .wb_done           (wb_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int re_mode = 0;   // 0: low, 1: high, 2: random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (word stream + burst addresses) -----
    logic [15:0] exp_q [$];
    logic [29:0] addr_q [$];
    int          m_total = 0;
    int          m_enq   = 0;
    logic [29:0] m_next  = '0;
    int          vcount  = 0;
    logic        re_prev = 1'b0;
    logic [29:0] p0_prev = '0;
    logic        chk_wen_fall = 1'b0;

    always @(negedge clk) begin
        int n;
        if (chk_wen_fall) begin
            check("writes_en_fall_after_done", dma_p0_writes_en, 0);
            chk_wen_fall = 1'b0;
        end
        if (dma_p0_ib_valid) begin
            check("valid_follows_re", re_prev, 1);
            check("word_expected", exp_q.size() != 0, 1);
            vcount++;
            if (exp_q.size() != 0) begin
                check("word_data", dma_p0_ib_data, exp_q.pop_front());
                check("word_burst_addr", p0_prev, addr_q.pop_front());
            end
        end
        if (wb_done) begin
            check("done_word_count", vcount, m_total);
            if (m_total != 0) begin
                check("done_with_last_valid", dma_p0_ib_valid, 1);
                check("writes_en_at_done", dma_p0_writes_en, 1);
            end
            chk_wen_fall = 1'b1;
        end
        re_prev = dma_p0_ib_re;
        p0_prev = p0_addr;
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            chk_wen_fall = 1'b0;
        end else begin
            if (start) begin
                m_total = int'(total_words);
                m_next  = result_start_addr;
                m_enq   = 0;
                vcount  = 0;
                exp_q.delete();
                addr_q.delete();
            end
            if (res_valid && res_ready) begin
                n = (res_lanes == 0 || res_lanes > 5'd16) ? 16 : int'(res_lanes);
                for (int i = 0; i < n; i++) begin
                    if (m_enq < m_total) begin
                        exp_q.push_back(res_data[16*i +: 16]);
                        addr_q.push_back(m_next);
                        m_enq++;
                    end
                end
                m_next = m_next + 30'(n);
            end
        end
    end

    // ---------------- DMA strobe driver ------------------------------------
    initial begin
        dma_p0_ib_re = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (re_mode)
                0:       dma_p0_ib_re = 1'b0;
                1:       dma_p0_ib_re = 1'b1;
                default: dma_p0_ib_re = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [29:0] base, input logic [23:0] total);
        result_start_addr = base;
        total_words       = total;
        start             = 1'b1;
        tick();
        start             = 1'b0;
    endtask

    task automatic offer(input logic [BL*16-1:0] d, input logic [4:0] l);
        logic acc;
        acc       = 1'b0;
        res_valid = 1'b1;
        res_data  = d;
        res_lanes = l;
        for (int c = 0; c < 400; c++) begin
            acc = res_ready;
            tick();
            if (acc) break;
        end
        res_valid = 1'b0;
        check("offer_accepted", acc, 1);
    endtask

    task automatic wait_done(input int bound);
        logic got;
        got = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (wb_done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", got, 1);
    endtask

    function automatic logic [BL*16-1:0] rand_burst();
        logic [BL*16-1:0] d;
        for (int i = 0; i < BL; i++) d[16*i +: 16] = 16'($urandom_range(0, 65535));
        return d;
    endfunction

    // ---------------- vector table -----------------------------------------
    typedef struct packed {
        logic [29:0]      base;
        logic [23:0]      total;
        logic [2:0]       nb;
        logic [3:0][4:0]  lanes;
        logic [1:0]       re_md;
        logic [23:0]      exp_pulses;
        logic [29:0]      exp_addr;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    function automatic vec_t mkvec(input logic [29:0] base, input logic [23:0] total,
                                   input logic [2:0] nb, input logic [4:0] l0,
                                   input logic [4:0] l1, input logic [4:0] l2,
                                   input logic [1:0] re_md, input logic [23:0] ep,
                                   input logic [29:0] ea);
        vec_t v;
        v.base = base; v.total = total; v.nb = nb;
        v.lanes[0] = l0; v.lanes[1] = l1; v.lanes[2] = l2; v.lanes[3] = 5'd0;
        v.re_md = re_md; v.exp_pulses = ep; v.exp_addr = ea;
        return v;
    endfunction

    initial begin
        logic [BL*16-1:0] d;
        int acc;
        logic was;

        vecs[0] = mkvec(30'h100,       24'd16, 3'd1, 5'd16, 5'd0,  5'd0,  2'd1, 24'd16, 30'h100);
        vecs[1] = mkvec(30'h100,       24'd40, 3'd3, 5'd16, 5'd16, 5'd16, 2'd1, 24'd40, 30'h120);
        vecs[2] = mkvec(30'h100,       24'd37, 3'd3, 5'd5,  5'd0,  5'd20, 2'd1, 24'd37, 30'h115);
        vecs[3] = mkvec(30'h3FFF_FFF8, 24'd20, 3'd2, 5'd16, 5'd16, 5'd0,  2'd1, 24'd20, 30'h8);
        vecs[4] = mkvec(30'h4000,      24'd30, 3'd3, 5'd7,  5'd16, 5'd9,  2'd2, 24'd30, 30'h4017);
        vecs[5] = mkvec(30'h20,        24'd3,  3'd3, 5'd1,  5'd1,  5'd1,  2'd2, 24'd3,  30'h22);
        vecs[6] = mkvec(30'h50,        24'd0,  3'd0, 5'd0,  5'd0,  5'd0,  2'd1, 24'd0,  30'h22);

        rst = 1'b1; start = 1'b0; res_valid = 1'b0; res_data = '0; res_lanes = '0;
        result_start_addr = '0; total_words = '0;
        tick(); tick(); tick();
        check("rst_res_ready", res_ready, 0);
        check("rst_writes_en", dma_p0_writes_en, 0);
        check("rst_p0_addr", p0_addr, 0);
        check("rst_ib_data", dma_p0_ib_data, 0);
        check("rst_ib_valid", dma_p0_ib_valid, 0);
        check("rst_busy", wb_busy, 0);
        check("rst_done", wb_done, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < NV; v++) begin
            re_mode = int'(vecs[v].re_md);
            do_start(vecs[v].base, vecs[v].total);
            if (vecs[v].total != 0) check("busy_after_start", wb_busy, 1);
            for (int b = 0; b < int'(vecs[v].nb); b++) begin
                if (v == 0) begin
                    for (int i = 0; i < BL; i++) d[16*i +: 16] = 16'(i);
                end else begin
                    d = rand_burst();
                end
                offer(d, vecs[v].lanes[b]);
            end
            wait_done(2000);
            tick(); tick();
            check("vec_valid_pulses", vcount, vecs[v].exp_pulses);
            check("vec_final_p0_addr", p0_addr, vecs[v].exp_addr);
            check("vec_idle_busy", wb_busy, 0);
            check("vec_idle_ready", res_ready, 0);
        end

        // Back-pressure: strobes held low, keep offering until the buffer stalls.
        re_mode = 0;
        do_start(30'h200, 24'd48);
        acc = 0;
        d = rand_burst();
        for (int c = 0; c < 20; c++) begin
            res_valid = (acc < 3);
            res_data  = d;
            res_lanes = 5'd16;
            was = res_valid && res_ready;
            tick();
            if (was) begin
                acc++;
                d = rand_burst();
            end
        end
        res_valid = 1'b0;
        check("bp_accepts_at_most_3", acc <= 3, 1);
        check("bp_accepts_at_least_2", acc >= 2, 1);
        check("bp_ready_low_when_full", res_ready, 0);
        check("bp_no_words_without_re", vcount, 0);
        check("bp_writes_en_held", dma_p0_writes_en, 1);
        re_mode = 1;
        while (acc < 3) begin
            offer(rand_burst(), 5'd16);
            acc++;
        end
        wait_done(2000);
        tick(); tick();
        check("bp_valid_pulses", vcount, 48);
        check("bp_final_p0_addr", p0_addr, 30'h220);

        // Reset in the middle of a burst, then a fresh short layer.
        re_mode = 1;
        do_start(30'h300, 24'd16);
        offer(rand_burst(), 5'd16);
        for (int c = 0; c < 100 && vcount < 7; c++) tick();
        check("mid_reached_word7", vcount >= 7, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_res_ready", res_ready, 0);
        check("mid_rst_writes_en", dma_p0_writes_en, 0);
        check("mid_rst_p0_addr", p0_addr, 0);
        check("mid_rst_ib_data", dma_p0_ib_data, 0);
        check("mid_rst_ib_valid", dma_p0_ib_valid, 0);
        check("mid_rst_busy", wb_busy, 0);
        check("mid_rst_done", wb_done, 0);
        rst = 1'b0;
        tick();
        do_start(30'h340, 24'd4);
        offer(rand_burst(), 5'd16);
        wait_done(200);
        tick(); tick();
        check("post_rst_valid_pulses", vcount, 4);
        check("post_rst_p0_addr", p0_addr, 30'h340);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
